control_sequencer: RTL and testbench

Hardwired control unit that drives the single-bus datapath's control inputs, instruction by instruction. It sequences fetch (T0–T2) and execute (T3–T6) for register-to-register ALU instructions and a small set of system instructions. It reads the instruction register contents back from the datapath and stalls in the memory-read phase until memory signals ready. It sits directly upstream of the datapath and replaces hand-driven control stimulus.

---
 rtl/cpu_ctrl_pkg.sv | 48 ++++
 rtl/instr_decoder.sv | 30 +++
 rtl/control_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control sequencer: opcodes,
// IR field positions, FSM state and instruction-class enums.
package cpu_ctrl_pkg;

  localparam int OP_LO = 27;
  localparam int RA_LO = 23;
  localparam int RB_LO = 19;
  localparam int RC_LO = 15;
  localparam int RF_W  = 4;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01001;
  localparam logic [4:0] OP_DIV  = 5'b01010;
  localparam logic [4:0] OP_NEG  = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_BIN,
    C_MULDIV,
    C_UNARY,
    C_NOP,
    C_HALT,
    C_ILL
  } cls_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode classifier.
// Ports: opcode in (OPW bits), cls out (instruction class).
import cpu_ctrl_pkg::*;

module instr_decoder #(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output cls_e           cls
);

  always_comb begin
    cls = C_ILL;
    unique case (1'b1)
      (opcode <= OP_ROL):
        cls = C_BIN;
      (opcode == OP_MUL) || (opcode == OP_DIV):
        cls = C_MULDIV;
      (opcode == OP_NEG) || (opcode == OP_NOT):
        cls = C_UNARY;
      (opcode == OP_NOP):
        cls = C_NOP;
      (opcode == OP_HALT):
        cls = C_HALT;
      default:
        cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit for the single-bus datapath.
// Ports: clk, clr (sync active-low), run, ir, mem_ready in; one-hot
// R_rd/R_wrt, bus drivers, register loads, IncPC, Read, op_sel,
// halted and illegal out.
import cpu_ctrl_pkg::*;

module control_sequencer #(
  parameter int NREG = 16,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            run,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic [NREG-1:0] R_rd,
  output logic [NREG-1:0] R_wrt,
  output logic            PC_out,
  output logic            MDR_out,
  output logic            Zlo_out,
  output logic            Zhi_out,
  output logic            MAR_rd,
  output logic            PC_rd,
  output logic            MDR_rd,
  output logic            IR_rd,
  output logic            Y_rd,
  output logic            Zlo_rd,
  output logic            Zhi_rd,
  output logic            HI_rd,
  output logic            LO_rd,
  output logic            IncPC,
  output logic            Read,
  output logic [OPW-1:0]  op_sel,
  output logic            halted,
  output logic            illegal
);

  function automatic logic [NREG-1:0] onehot(
    input logic [RF_W-1:0] f
  );
    onehot = '0;
    for (int i = 0; i < NREG; i++)
      if (f == RF_W'(i)) onehot[i] = 1'b1;
  endfunction

  state_e          state_q;
  state_e          state_d;
  state_e          eoi;
  cls_e            cls;
  logic            ill_q;
  logic [OPW-1:0]  opcode;
  logic [NREG-1:0] oh_a;
  logic [NREG-1:0] oh_b;
  logic [NREG-1:0] oh_c;
  logic            alu2;
  logic            unused_ir;

  assign opcode    = ir[OP_LO +: OPW];
  assign oh_a      = onehot(ir[RA_LO +: RF_W]);
  assign oh_b      = onehot(ir[RB_LO +: RF_W]);
  assign oh_c      = onehot(ir[RC_LO +: RF_W]);
  assign unused_ir = ^ir[RC_LO-1:0];
  assign alu2      = (cls == C_BIN) || (cls == C_MULDIV);
  assign eoi       = run ? S_T0 : S_IDLE;

  instr_decoder #(
    .OPW(OPW)
  ) u_dec (
    .opcode(opcode),
    .cls   (cls)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // flagged at the end of T2, seen for one cycle after it
      ill_q   <= (state_q == S_T2) && (cls == C_ILL);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: state_d = run ? S_T0 : S_IDLE;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = mem_ready ? S_T2 : S_T1;
      S_T2: begin
        unique case (cls)
          C_HALT:      state_d = S_HALT;
          C_NOP, C_ILL: state_d = eoi;
          default:     state_d = S_T3;
        endcase
      end
      S_T3: begin
        if (cls == C_UNARY)
          state_d = S_T5;
        else if (alu2)
          state_d = S_T4;
        else
          state_d = eoi;
      end
      S_T4: state_d = alu2 ? S_T5 : eoi;
      S_T5: state_d = (cls == C_MULDIV) ? S_T6 : eoi;
      S_T6: state_d = eoi;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    R_rd    = '0;
    R_wrt   = '0;
    PC_out  = 1'b0;
    MDR_out = 1'b0;
    Zlo_out = 1'b0;
    Zhi_out = 1'b0;
    MAR_rd  = 1'b0;
    PC_rd   = 1'b0;
    MDR_rd  = 1'b0;
    IR_rd   = 1'b0;
    Y_rd    = 1'b0;
    Zlo_rd  = 1'b0;
    Zhi_rd  = 1'b0;
    HI_rd   = 1'b0;
    LO_rd   = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    op_sel  = '0;
    halted  = 1'b0;
    illegal = ill_q;
    unique case (state_q)
      S_T0: begin
        PC_out = 1'b1;
        MAR_rd = 1'b1;
        IncPC  = 1'b1;
      end
      S_T1: begin
        Read   = 1'b1;
        MDR_rd = 1'b1;
      end
      S_T2: begin
        MDR_out = 1'b1;
        IR_rd   = 1'b1;
      end
      S_T3: begin
        if (alu2) begin
          R_wrt = oh_b;
          Y_rd  = 1'b1;
        end else if (cls == C_UNARY) begin
          R_wrt  = oh_b;
          op_sel = opcode;
          Zlo_rd = 1'b1;
        end
      end
      S_T4: begin
        if (alu2) begin
          R_wrt  = oh_c;
          op_sel = opcode;
          Zlo_rd = 1'b1;
          Zhi_rd = (cls == C_MULDIV);
        end
      end
      S_T5: begin
        if (cls == C_MULDIV) begin
          Zlo_out = 1'b1;
          LO_rd   = 1'b1;
        end else if ((cls == C_BIN) || (cls == C_UNARY)) begin
          Zlo_out = 1'b1;
          R_rd    = oh_a;
        end
      end
      S_T6: begin
        if (cls == C_MULDIV) begin
          Zhi_out = 1'b1;
          HI_rd   = 1'b1;
        end
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
// Drives inputs on the falling edge, checks all outputs there.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic [15:0] R_rd;
  logic [15:0] R_wrt;
  logic        PC_out, MDR_out, Zlo_out, Zhi_out;
  logic        MAR_rd, PC_rd, MDR_rd, IR_rd, Y_rd;
  logic        Zlo_rd, Zhi_rd, HI_rd, LO_rd;
  logic        IncPC, Read;
  logic [4:0]  op_sel;
  logic        halted, illegal;

  int vectors = 0;
  int errors  = 0;

  localparam logic [16:0] F_PCO  = 17'h10000;
  localparam logic [16:0] F_MDRO = 17'h08000;
  localparam logic [16:0] F_ZLOO = 17'h04000;
  localparam logic [16:0] F_ZHIO = 17'h02000;
  localparam logic [16:0] F_MAR  = 17'h01000;
  localparam logic [16:0] F_MDRR = 17'h00400;
  localparam logic [16:0] F_IRR  = 17'h00200;
  localparam logic [16:0] F_Y    = 17'h00100;
  localparam logic [16:0] F_ZLOR = 17'h00080;
  localparam logic [16:0] F_ZHIR = 17'h00040;
  localparam logic [16:0] F_HI   = 17'h00020;
  localparam logic [16:0] F_LO   = 17'h00010;
  localparam logic [16:0] F_INC  = 17'h00008;
  localparam logic [16:0] F_RD   = 17'h00004;
  localparam logic [16:0] F_HLT  = 17'h00002;
  localparam logic [16:0] F_ILL  = 17'h00001;

  localparam logic [16:0] T0F = F_PCO | F_MAR | F_INC;
  localparam logic [16:0] T1F = F_RD | F_MDRR;
  localparam logic [16:0] T2F = F_MDRO | F_IRR;

  localparam logic [31:0] IR_ROL  = 32'h421B8000;
  localparam logic [31:0] IR_MUL  = 32'h481B8000;
  localparam logic [31:0] IR_NOT  = 32'h60A80000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_BAD  = 32'hF8000000;

  control_sequencer dut (
    .clk      (clk),
    .clr      (clr),
    .run      (run),
    .ir       (ir),
    .mem_ready(mem_ready),
    .R_rd     (R_rd),
    .R_wrt    (R_wrt),
    .PC_out   (PC_out),
    .MDR_out  (MDR_out),
    .Zlo_out  (Zlo_out),
    .Zhi_out  (Zhi_out),
    .MAR_rd   (MAR_rd),
    .PC_rd    (PC_rd),
    .MDR_rd   (MDR_rd),
    .IR_rd    (IR_rd),
    .Y_rd     (Y_rd),
    .Zlo_rd   (Zlo_rd),
    .Zhi_rd   (Zhi_rd),
    .HI_rd    (HI_rd),
    .LO_rd    (LO_rd),
    .IncPC    (IncPC),
    .Read     (Read),
    .op_sel   (op_sel),
    .halted   (halted),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic cyc(
    input string       tag,
    input logic [15:0] rrd,
    input logic [15:0] rwrt,
    input logic [16:0] fl,
    input logic [4:0]  op
  );
    logic [53:0] obs;
    logic [53:0] exp;
    @(negedge clk);
    obs = {R_rd, R_wrt, PC_out, MDR_out, Zlo_out, Zhi_out,
           MAR_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd,
           Zhi_rd, HI_rd, LO_rd, IncPC, Read, halted,
           illegal, op_sel};
    exp = {rrd, rwrt, fl, op};
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic cf(input string tag, input logic [16:0] fl);
    cyc(tag, 16'h0, 16'h0, fl, 5'b0);
  endtask

  initial begin
    clr       = 1'b0;
    run       = 1'b0;
    ir        = 32'h0;
    mem_ready = 1'b1;

    cf("reset", 17'h0);
    clr = 1'b1;
    cf("idle", 17'h0);
    run = 1'b1;
    ir  = IR_ROL;

    cf("rol_t0", T0F);
    cf("rol_t1", T1F);
    cf("rol_t2", T2F);
    cyc("rol_t3", 16'h0, 16'h0008, F_Y, 5'b0);
    cyc("rol_t4", 16'h0, 16'h0080, F_ZLOR, 5'b01000);
    cyc("rol_t5", 16'h0010, 16'h0, F_ZLOO, 5'b0);

    cf("mul_t0", T0F);
    ir = IR_MUL;
    cf("mul_t1", T1F);
    cf("mul_t2", T2F);
    cyc("mul_t3", 16'h0, 16'h0008, F_Y, 5'b0);
    cyc("mul_t4", 16'h0, 16'h0080, F_ZLOR | F_ZHIR, 5'b01001);
    cf("mul_t5", F_ZLOO | F_LO);
    cf("mul_t6", F_ZHIO | F_HI);

    cf("not_t0", T0F);
    ir        = IR_NOT;
    mem_ready = 1'b0;
    cf("not_wait1", T1F);
    cf("not_wait2", T1F);
    cf("not_wait3", T1F);
    cf("not_wait4", T1F);
    mem_ready = 1'b1;
    cf("not_t2", T2F);
    cyc("not_t3", 16'h0, 16'h0020, F_ZLOR, 5'b01100);
    cyc("not_t5", 16'h0002, 16'h0, F_ZLOO, 5'b0);

    cf("nop_t0", T0F);
    ir = IR_NOP;
    cf("nop_t1", T1F);
    cf("nop_t2", T2F);

    cf("bad_t0", T0F);
    ir = IR_BAD;
    cf("bad_t1", T1F);
    cf("bad_t2", T2F);
    cf("bad_pulse", T0F | F_ILL);
    ir  = IR_NOP;
    run = 1'b0;
    cf("ill_once", T1F);
    cf("run0_t2", T2F);
    cf("run0_idle", 17'h0);
    cf("idle_hold", 17'h0);
    run = 1'b1;
    ir  = IR_HALT;

    cf("halt_t0", T0F);
    cf("halt_t1", T1F);
    cf("halt_t2", T2F);
    cf("halted", F_HLT);
    cf("halt_stay", F_HLT);
    clr = 1'b0;
    cf("halt_clr", 17'h0);
    clr = 1'b1;
    ir  = IR_ROL;

    cf("r2_t0", T0F);
    cf("r2_t1", T1F);
    cf("r2_t2", T2F);
    cyc("r2_t3", 16'h0, 16'h0008, F_Y, 5'b0);
    cyc("r2_t4", 16'h0, 16'h0080, F_ZLOR, 5'b01000);
    clr = 1'b0;
    cf("t4_clr", 17'h0);
    clr = 1'b1;
    cf("clr_t0", T0F);
    mem_ready = 1'b0;
    cf("w_t1", T1F);
    clr = 1'b0;
    cf("wait_clr", 17'h0);
    clr       = 1'b1;
    mem_ready = 1'b1;
    cf("wclr_t0", T0F);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
